// File: rtl/sha256_padder.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_padder
//  Description : Packs a byte stream into 512-bit SHA-256 blocks and applies
//                standard message padding (0x80, zero fill, 64-bit length).
//                Each block is offered as a one-cycle blk_valid pulse gated
//                by the downstream pause input.
//  Revision    : 1.0 - initial release
// ============================================================================
module sha256_padder #(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_byte,
    input  logic         in_last,
    input  logic         pause,
    output logic         blk_valid,
    output logic [511:0] blk_out,
    output logic         blk_is_last,
    output logic         busy
);

    // Bit position of the most significant bit of byte 0 in a block.
    localparam logic [8:0]         c_top_bit = 9'd511;
    localparam logic [LEN_W-4:0]   c_len_one = {{(LEN_W-4){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        FILL       = 3'd0,
        PAD        = 3'd1,
        EMIT_DATA  = 3'd2,
        EMIT_PRE   = 3'd3,
        BUILD      = 3'd4,
        EMIT_FINAL = 3'd5
    } state_t;

    state_t           r_state;
    logic [5:0]       r_idx;        // next byte slot within the block
    logic [6:0]       r_fill;       // bytes in the block holding the last byte (1..64)
    logic [LEN_W-4:0] r_len;        // message length in bytes
    logic [511:0]     r_buf;        // block under assembly
    logic [511:0]     r_out;        // block presented downstream
    logic             r_out_last;
    logic             r_need_80;    // extra block must start with the 0x80 marker
    logic             r_busy;

    logic             w_xfer;
    logic             w_emit;
    logic [LEN_W-1:0] w_bitlen;
    logic [511:0]     w_buf_wr;
    logic [511:0]     w_pad;
    logic [7:0]       w_lead_byte;

    assign w_xfer      = in_valid && in_ready;
    assign w_emit      = (r_state == EMIT_DATA) || (r_state == EMIT_PRE) ||
                         (r_state == EMIT_FINAL);
    assign w_bitlen    = {r_len, 3'b000};
    assign w_lead_byte = r_need_80 ? 8'h80 : 8'h00;

    assign in_ready    = (r_state == FILL);
    // pause is honoured in the very cycle the pulse would appear.
    assign blk_valid   = w_emit && !pause;
    assign blk_out     = r_out;
    assign blk_is_last = r_out_last;
    assign busy        = r_busy;

    // Current buffer with the incoming byte merged into its slot.
    always_comb begin
        w_buf_wr = r_buf;
        w_buf_wr[c_top_bit - {r_idx, 3'b000} -: 8] = in_byte;
    end

    // Padded form of the buffer: marker after the data, length if it fits.
    always_comb begin
        w_pad = r_buf;
        if (r_fill < 7'd64) begin
            w_pad[c_top_bit - {r_fill[5:0], 3'b000} -: 8] = 8'h80;
        end
        if (r_fill <= 7'd55) begin
            w_pad[LEN_W-1:0] = w_bitlen;
        end
    end

    // Control FSM with block assembly, padding and emission handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= FILL;
            r_idx      <= '0;
            r_fill     <= '0;
            r_len      <= '0;
            r_buf      <= '0;
            r_out      <= '0;
            r_out_last <= 1'b0;
            r_need_80  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_xfer) begin
                        r_len  <= r_len + c_len_one;
                        r_idx  <= r_idx + 6'd1;
                        r_busy <= 1'b1;
                        if (in_last) begin
                            r_buf   <= w_buf_wr;
                            r_fill  <= {1'b0, r_idx} + 7'd1;
                            r_state <= PAD;
                        end else if (r_idx == 6'd63) begin
                            // Full data block: hand it off and start a fresh one.
                            r_out      <= w_buf_wr;
                            r_out_last <= 1'b0;
                            r_buf      <= '0;
                            r_state    <= EMIT_DATA;
                        end else begin
                            r_buf <= w_buf_wr;
                        end
                    end
                end
                PAD: begin
                    r_out     <= w_pad;
                    r_buf     <= '0;
                    r_idx     <= '0;
                    r_need_80 <= (r_fill == 7'd64);
                    if (r_fill <= 7'd55) begin
                        r_out_last <= 1'b1;
                        r_state    <= EMIT_FINAL;
                    end else begin
                        r_out_last <= 1'b0;
                        r_state    <= EMIT_PRE;
                    end
                end
                EMIT_DATA: begin
                    if (!pause) begin
                        r_state <= FILL;
                    end
                end
                EMIT_PRE: begin
                    if (!pause) begin
                        r_state <= BUILD;
                    end
                end
                BUILD: begin
                    // Extra block: optional marker, zero fill, bit length.
                    r_out      <= {w_lead_byte, {(504-LEN_W){1'b0}}, w_bitlen};
                    r_out_last <= 1'b1;
                    r_state    <= EMIT_FINAL;
                end
                EMIT_FINAL: begin
                    if (!pause) begin
                        r_len   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= FILL;
                    end
                end
                default: begin
                    r_state <= FILL;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sha256_padder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sha256_padder
//  Description : Scoreboard bench for sha256_padder. Stimulus pushes expected
//                blocks into a queue; a monitor pops and compares on pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sha256_padder;

    typedef struct packed {
        logic [511:0] data;
        logic         last;
    } blk_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_byte;
    logic         in_last;
    logic         pause;
    logic         blk_valid;
    logic [511:0] blk_out;
    logic         blk_is_last;
    logic         busy;

    blk_t       exp_q[$];
    logic [7:0] msg[$];
    int         n_checks   = 0;
    int         n_errors   = 0;
    int         n_pulses   = 0;
    int         cyc        = 0;
    int         last_pulse = -100;
    logic       pause_mode = 1'b0;

    sha256_padder #(.LEN_W(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_byte    (in_byte),
        .in_last    (in_last),
        .pause      (pause),
        .blk_valid  (blk_valid),
        .blk_out    (blk_out),
        .blk_is_last(blk_is_last),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every pulse is checked against the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && blk_valid) begin
            blk_t e;
            n_pulses++;
            chk("pulse_while_paused", 512'(pause), 512'(0));
            chk("in_ready_during_pulse", 512'(in_ready), 512'(0));
            chk("pulse_gap_ok", 512'(cyc - last_pulse >= 2), 512'(1));
            last_pulse = cyc;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_pulse: got pulse with blk_out %h expected none", blk_out);
            end else begin
                e = exp_q.pop_front();
                chk("blk_out", blk_out, e.data);
                chk("blk_is_last", 512'(blk_is_last), 512'(e.last));
            end
        end
    end

    // Downstream model for the stall scenario: busy for 50 cycles after each pulse.
    initial begin
        pause = 1'b0;
        forever begin
            @(negedge clk);
            if (pause_mode && blk_valid) begin
                @(posedge clk);
                #1 pause = 1'b1;
                repeat (50) @(posedge clk);
                #1 pause = 1'b0;
            end
        end
    end

    // Reference padding: append 0x80, zero fill to 56 mod 64, 64-bit length.
    task automatic push_model();
        logic [7:0]  p[$];
        logic [63:0] bitlen;
        blk_t        b;
        int          nblk;
        p      = msg;
        bitlen = 64'(msg.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int k = 7; k >= 0; k--) p.push_back(bitlen[8*k+7 -: 8]);
        nblk = p.size() / 64;
        for (int bi = 0; bi < nblk; bi++) begin
            b.data = '0;
            for (int i = 0; i < 64; i++) b.data[511-8*i -: 8] = p[bi*64+i];
            b.last = (bi == nblk - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_accept();
        int   t;
        logic rdy;
        t   = 0;
        rdy = 1'b0;
        while (!rdy && t < 5000) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        if (!rdy) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: got in_ready low for %0d cycles expected accept", t);
        end
    endtask

    task automatic send_msg();
        for (int i = 0; i < msg.size(); i++) begin
            in_valid = 1'b1;
            in_byte  = msg[i];
            in_last  = (i == msg.size() - 1);
            wait_accept();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_byte  = 8'h00;
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        chk({name, "_drained"}, 512'(exp_q.size()), 512'(0));
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_busy_idle"}, 512'(busy), 512'(0));
        chk({name, "_ready_idle"}, 512'(in_ready), 512'(1));
    endtask

    task automatic push_abc();
        blk_t b;
        b.data           = '0;
        b.data[511:480]  = 32'h6162_6380;
        b.data[63:0]     = 64'h18;
        b.last           = 1'b1;
        exp_q.push_back(b);
        msg = '{8'h61, 8'h62, 8'h63};
    endtask

    initial begin
        blk_t b;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        in_last  = 1'b0;
        #23;
        chk("rst_in_ready", 512'(in_ready), 512'(1));
        chk("rst_blk_valid", 512'(blk_valid), 512'(0));
        chk("rst_blk_out", blk_out, 512'(0));
        chk("rst_blk_is_last", 512'(blk_is_last), 512'(0));
        chk("rst_busy", 512'(busy), 512'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // "abc"
        push_abc();
        send_msg();
        wait_done("abc");

        // 55 zero bytes: single block
        b.data = '0;
        b.data[511-8*55 -: 8] = 8'h80;
        b.data[63:0] = 64'h1B8;
        b.last = 1'b1;
        exp_q.push_back(b);
        msg = {};
        for (int i = 0; i < 55; i++) msg.push_back(8'h00);
        send_msg();
        wait_done("len55");

        // 56 bytes of 0xFF: marker ends block 1, length alone in block 2
        b.data = '0;
        b.data[511:64] = {56{8'hFF}};
        b.data[63:56] = 8'h80;
        b.last = 1'b0;
        exp_q.push_back(b);
        b.data = '0;
        b.data[63:0] = 64'h1C0;
        b.last = 1'b1;
        exp_q.push_back(b);
        msg = {};
        for (int i = 0; i < 56; i++) msg.push_back(8'hFF);
        send_msg();
        wait_done("len56");

        // 64 bytes of 0xAA: marker starts the extra block
        b.data = {64{8'hAA}};
        b.last = 1'b0;
        exp_q.push_back(b);
        b.data = '0;
        b.data[511:504] = 8'h80;
        b.data[63:0] = 64'h200;
        b.last = 1'b1;
        exp_q.push_back(b);
        msg = {};
        for (int i = 0; i < 64; i++) msg.push_back(8'hAA);
        send_msg();
        wait_done("len64");

        // 130 bytes with downstream stalling 50 cycles after every pulse
        pause_mode = 1'b1;
        msg = {};
        for (int i = 0; i < 130; i++) msg.push_back(8'(i) ^ 8'h5A);
        push_model();
        chk("len130_final_len", exp_q[2].data[63:0], 512'(64'h410));
        send_msg();
        wait_done("len130");
        repeat (60) @(posedge clk);
        #1;
        pause_mode = 1'b0;

        // Reset while byte 20 of a message is on the bus
        msg = {};
        for (int i = 0; i < 20; i++) msg.push_back(8'h11 + 8'(i));
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_byte  = msg[i];
            in_last  = 1'b0;
            wait_accept();
        end
        in_byte = 8'h99;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_in_ready", 512'(in_ready), 512'(1));
        chk("midrst_busy", 512'(busy), 512'(0));
        chk("midrst_blk_out", blk_out, 512'(0));
        in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        push_abc();
        send_msg();
        wait_done("abc_after_rst");

        repeat (5) @(posedge clk);
        #1;
        chk("total_pulses", 512'(n_pulses), 512'(10));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
